// File: rtl/mips_run_ctrl_pkg.sv
// Shared state encoding, run-mode constants and helpers for the MIPS run/step controller.
package mips_ctrl_pkg;

   typedef enum logic [1:0] {
      HALT   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      RSTSEQ = 2'd3
   } state_t;

   localparam logic [1:0] MODE_FULL  = 2'b00;
   localparam logic [1:0] MODE_SLOW  = 2'b01;
   localparam logic [1:0] MODE_VSLOW = 2'b10;
   localparam logic [1:0] MODE_BP    = 2'b11;

   localparam int DIV_W = 26;

   function automatic logic mode_is_slow(input logic [1:0] mode);
      return (mode == MODE_SLOW) || (mode == MODE_VSLOW);
   endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Board-side signals of the run controller: key/switch levels and PC in, CPU control out.
interface mips_run_ctrl_if;
   logic [1:0]  KEY;
   logic [9:0]  SW;
   logic [31:0] PC;
   logic        CPU_EN;
   logic        CPU_RST;
   logic        RUNNING;
   logic [15:0] STEP_CNT;

   modport master (
      input  KEY, SW, PC,
      output CPU_EN, CPU_RST, RUNNING, STEP_CNT
   );

   modport slave (
      output KEY, SW, PC,
      input  CPU_EN, CPU_RST, RUNNING, STEP_CNT
   );
endinterface

// File: rtl/mips_run_ctrl_div.sv
// Slow-run rate divider: 1-cycle tick every SLOW_DIV or VSLOW_DIV enabled cycles.
module run_rate_div
   import mips_ctrl_pkg::*;
#(
   parameter int SLOW_DIV  = 12500000,
   parameter int VSLOW_DIV = 50000000
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic enable,
   input  logic sel_vslow,
   output logic tick
);
   localparam logic [DIV_W-1:0] SLOW_LAST  = DIV_W'(SLOW_DIV - 1);
   localparam logic [DIV_W-1:0] VSLOW_LAST = DIV_W'(VSLOW_DIV - 1);

   logic [DIV_W-1:0] cnt_q, cnt_d, last;

   always_comb begin
      last  = sel_vslow ? VSLOW_LAST : SLOW_LAST;
      tick  = enable && !clear && (cnt_q == last);
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable)
         cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mips_run_ctrl.sv
// Run/step controller: sequences CPU clock-enable and reset from debounced keys and switches.
module mips_run_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int SLOW_DIV  = 12500000,
   parameter int VSLOW_DIV = 50000000,
   parameter int RST_CYC   = 16
) (
   input  logic            CLK,
   input  logic            RST,
   mips_run_ctrl_if.master bus
);
   localparam int              RC_W    = $clog2(RST_CYC) + 1;
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

   state_t            state_q, state_d;
   logic [1:0]        key_q, key_d, mode_q, mode_d, mode, press;
   logic              skip_bp_q, skip_bp_d;
   logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
   logic              cpu_en_q, cpu_en_d, cpu_rst_q, cpu_rst_d, running_q, running_d;
   logic [15:0]       step_cnt_q, step_cnt_d;
   logic              rst_trig, bp_hit, div_clr, div_en, div_tick;
   logic              unused_pc;

   assign mode      = bus.SW[9:8];
   assign press     = key_q & ~bus.KEY;
   assign rst_trig  = (press[0] && !bus.KEY[1]) || (press[1] && !bus.KEY[0]);
   assign bp_hit    = (mode == MODE_BP) && (bus.PC[9:2] == bus.SW[7:0]) && !skip_bp_q;
   assign unused_pc = ^{bus.PC[31:10], bus.PC[1:0]};

   // Holding the divider cleared outside RUN guarantees a fresh count on every entry.
   assign div_en  = (state_q == RUN) && mode_is_slow(mode);
   assign div_clr = (state_q != RUN) || (mode != mode_q);

   run_rate_div #(
      .SLOW_DIV  (SLOW_DIV),
      .VSLOW_DIV (VSLOW_DIV)
   ) u_div (
      .CLK       (CLK),
      .RST       (RST),
      .clear     (div_clr),
      .enable    (div_en),
      .sel_vslow (mode == MODE_VSLOW),
      .tick      (div_tick)
   );

   always_comb begin
      state_d   = state_q;
      skip_bp_d = skip_bp_q;
      rst_cnt_d = rst_cnt_q;
      cpu_en_d  = 1'b0;
      key_d     = bus.KEY;
      mode_d    = mode;
      unique case (state_q)
         HALT: begin
            if (press[1]) begin
               state_d   = RUN;
               skip_bp_d = 1'b1;
               cpu_en_d  = !mode_is_slow(mode);
            end else if (press[0]) begin
               state_d  = STEP;
               cpu_en_d = 1'b1;
            end
         end
         RUN: begin
            if (cpu_en_q)
               skip_bp_d = 1'b0;
            if (press[1] || bp_hit)
               state_d = HALT;
            else
               cpu_en_d = mode_is_slow(mode) ? div_tick : 1'b1;
         end
         STEP: state_d = HALT;
         RSTSEQ: begin
            rst_cnt_d = rst_cnt_q + RC_W'(1);
            if (rst_cnt_q == RC_LAST)
               state_d = HALT;
         end
      endcase
      // A two-key chord restarts the CPU reset sequence from any state.
      if (rst_trig) begin
         state_d   = RSTSEQ;
         rst_cnt_d = '0;
         cpu_en_d  = 1'b0;
      end
      cpu_rst_d  = (state_d == RSTSEQ);
      running_d  = (state_d == RUN);
      step_cnt_d = (state_d == RSTSEQ) ? 16'h0000 : step_cnt_q + {15'd0, cpu_en_q};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= HALT;
         key_q      <= 2'b00;
         mode_q     <= 2'b00;
         skip_bp_q  <= 1'b0;
         rst_cnt_q  <= '0;
         cpu_en_q   <= 1'b0;
         cpu_rst_q  <= 1'b0;
         running_q  <= 1'b0;
         step_cnt_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         mode_q     <= mode_d;
         skip_bp_q  <= skip_bp_d;
         rst_cnt_q  <= rst_cnt_d;
         cpu_en_q   <= cpu_en_d;
         cpu_rst_q  <= cpu_rst_d;
         running_q  <= running_d;
         step_cnt_q <= step_cnt_d;
      end
   end

   assign bus.CPU_EN   = cpu_en_q;
   assign bus.CPU_RST  = cpu_rst_q;
   assign bus.RUNNING  = running_q;
   assign bus.STEP_CNT = step_cnt_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: expected CPU_EN cycles are queued with the stimulus.
module tb_mips_run_ctrl;
   localparam int SLOW_DIV  = 8;
   localparam int VSLOW_DIV = 12;
   localparam int RST_CYC   = 16;

   logic CLK = 1'b0;
   logic RST;
   mips_run_ctrl_if bus ();

   mips_run_ctrl #(
      .SLOW_DIV  (SLOW_DIV),
      .VSLOW_DIV (VSLOW_DIV),
      .RST_CYC   (RST_CYC)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int          checks = 0;
   int          errors = 0;
   int          cyc_n  = 0;
   logic [31:0] pc     = '0;
   int          exp_q[$];
   int          obs_q[$];

   // One clock; CPU model: PC shows the next instruction once an enable is issued.
   task automatic cyc();
      @(posedge CLK);
      #1;
      cyc_n++;
      if (bus.CPU_EN === 1'b1) begin
         obs_q.push_back(cyc_n);
         pc     = pc + 32'd4;
         bus.PC = pc;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; bus.KEY = 2'b00; bus.SW = '0; bus.PC = '0;
      repeat (3) cyc();
      checks++;
      if ({bus.CPU_EN, bus.CPU_RST, bus.RUNNING} !== 3'b000 || bus.STEP_CNT !== 16'h0000) begin
         errors++;
         $display("FAIL reset_outputs: en/rst/run=%b cnt=%h, want 000 cnt=0000",
                  {bus.CPU_EN, bus.CPU_RST, bus.RUNNING}, bus.STEP_CNT);
      end
      RST = 1'b0;
      repeat (2) cyc();
      bus.KEY = 2'b11;
      repeat (4) begin
         cyc();
         checks++;
         if ({bus.CPU_EN, bus.CPU_RST, bus.RUNNING} !== 3'b000) begin
            errors++;
            $display("FAIL release_no_press: en/rst/run=%b, want 000",
                     {bus.CPU_EN, bus.CPU_RST, bus.RUNNING});
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL reset_en: %0d CPU_EN cycles, want 0", obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_step();
      int e, o;
      for (int k = 1; k <= 3; k++) begin
         bus.KEY = 2'b10;
         exp_q.push_back(cyc_n + 1);
         cyc();
         bus.KEY = 2'b11;
         repeat (3) cyc();
         checks++;
         if (bus.STEP_CNT !== 16'(k)) begin
            errors++;
            $display("FAIL step_cnt: STEP_CNT=%0d, want %0d", bus.STEP_CNT, k);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL step_pulse: CPU_EN at cycle %0d, want cycle %0d", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL step_extra: %0d extra CPU_EN cycles, want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_slow_run();
      int e, o, ent;
      bus.SW = 10'b01_0000_0000;
      cyc();
      bus.KEY = 2'b01;
      ent = cyc_n + 1;
      for (int i = 1; i <= 3; i++) exp_q.push_back(ent + i * SLOW_DIV);
      cyc();
      bus.KEY = 2'b11;
      checks++;
      if (bus.RUNNING !== 1'b1 || bus.CPU_EN !== 1'b0) begin
         errors++;
         $display("FAIL slow_entry: run=%b en=%b, want run=1 en=0", bus.RUNNING, bus.CPU_EN);
      end
      while (cyc_n < ent + 4 * SLOW_DIV - 1) cyc();
      bus.KEY = 2'b01;
      cyc();
      bus.KEY = 2'b11;
      checks++;
      if (bus.RUNNING !== 1'b0 || bus.CPU_EN !== 1'b0) begin
         errors++;
         $display("FAIL slow_halt: run=%b en=%b, want run=0 en=0", bus.RUNNING, bus.CPU_EN);
      end
      repeat (2 * SLOW_DIV) cyc();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL slow_pulse: CPU_EN at cycle %0d, want cycle %0d", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0 || bus.STEP_CNT !== 16'd6) begin
         errors++;
         $display("FAIL slow_extra: %0d extra pulses STEP_CNT=%0d, want 0 and 6",
                  obs_q.size(), bus.STEP_CNT);
         obs_q.delete();
      end
   endtask

   task automatic test_vslow_run();
      int e, o, ent;
      bus.SW = 10'b10_0000_0000;
      cyc();
      bus.KEY = 2'b01;
      ent = cyc_n + 1;
      for (int i = 1; i <= 2; i++) exp_q.push_back(ent + i * VSLOW_DIV);
      cyc();
      bus.KEY = 2'b11;
      while (cyc_n < ent + 2 * VSLOW_DIV) cyc();
      bus.KEY = 2'b01;
      cyc();
      bus.KEY = 2'b11;
      repeat (2 * VSLOW_DIV) cyc();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL vslow_pulse: CPU_EN at cycle %0d, want cycle %0d", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0 || bus.STEP_CNT !== 16'd8) begin
         errors++;
         $display("FAIL vslow_extra: %0d extra pulses STEP_CNT=%0d, want 0 and 8",
                  obs_q.size(), bus.STEP_CNT);
         obs_q.delete();
      end
   endtask

   task automatic test_breakpoint();
      int e, o, ent;
      pc = '0; bus.PC = pc;
      bus.SW = {2'b11, 8'h05};
      cyc();
      bus.KEY = 2'b01;
      ent = cyc_n + 1;
      for (int i = 0; i < 5; i++) exp_q.push_back(ent + i);
      cyc();
      bus.KEY = 2'b11;
      repeat (8) cyc();
      checks++;
      if (bus.RUNNING !== 1'b0 || bus.PC !== 32'h14) begin
         errors++;
         $display("FAIL bp_stop: run=%b PC=%h, want run=0 PC=00000014", bus.RUNNING, bus.PC);
      end
      bus.KEY = 2'b01;
      ent = cyc_n + 1;
      for (int i = 0; i < 5; i++) exp_q.push_back(ent + i);
      cyc();
      bus.KEY = 2'b11;
      while (cyc_n < ent + 4) cyc();
      bus.KEY = 2'b01;
      cyc();
      bus.KEY = 2'b11;
      repeat (3) cyc();
      checks++;
      if (bus.RUNNING !== 1'b0 || bus.PC !== 32'h28 || bus.STEP_CNT !== 16'd18) begin
         errors++;
         $display("FAIL bp_resume: run=%b PC=%h cnt=%0d, want run=0 PC=00000028 cnt=18",
                  bus.RUNNING, bus.PC, bus.STEP_CNT);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL bp_pulse: CPU_EN at cycle %0d, want cycle %0d", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL bp_extra: %0d extra CPU_EN cycles, want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_rstseq();
      int e, o, hi;
      bus.SW = '0;
      cyc();
      bus.KEY = 2'b01;
      exp_q.push_back(cyc_n + 1);
      cyc();
      bus.KEY = 2'b00;
      cyc();
      checks++;
      if (bus.CPU_RST !== 1'b1 || bus.CPU_EN !== 1'b0 || bus.RUNNING !== 1'b0 ||
          bus.STEP_CNT !== 16'h0000) begin
         errors++;
         $display("FAIL rstseq_entry: rst=%b en=%b run=%b cnt=%0d, want 1 0 0 0",
                  bus.CPU_RST, bus.CPU_EN, bus.RUNNING, bus.STEP_CNT);
      end
      hi = 1;
      bus.KEY = 2'b11;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (bus.CPU_RST === 1'b1) hi++;
      end
      checks++;
      if (hi != RST_CYC) begin
         errors++;
         $display("FAIL rstseq_len: CPU_RST high %0d cycles, want %0d", hi, RST_CYC);
      end
      checks++;
      if (bus.CPU_RST !== 1'b0 || bus.RUNNING !== 1'b0 || bus.STEP_CNT !== 16'h0000) begin
         errors++;
         $display("FAIL rstseq_exit: rst=%b run=%b cnt=%0d, want 0 0 0",
                  bus.CPU_RST, bus.RUNNING, bus.STEP_CNT);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rstseq_pulse: CPU_EN at cycle %0d, want cycle %0d", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL rstseq_extra: %0d extra CPU_EN cycles, want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_cnt_wrap();
      int ent;
      cyc();
      bus.KEY = 2'b01;
      ent = cyc_n + 1;
      cyc();
      bus.KEY = 2'b11;
      while (cyc_n < ent + 65534) cyc();
      bus.KEY = 2'b01;
      cyc();
      bus.KEY = 2'b11;
      checks++;
      if (bus.STEP_CNT !== 16'hFFFF || obs_q.size() != 65535) begin
         errors++;
         $display("FAIL cnt_preload: STEP_CNT=%h pulses=%0d, want FFFF and 65535",
                  bus.STEP_CNT, obs_q.size());
      end
      obs_q.delete();
      cyc();
      bus.KEY = 2'b10;
      cyc();
      bus.KEY = 2'b11;
      repeat (2) cyc();
      checks++;
      if (bus.STEP_CNT !== 16'h0000 || obs_q.size() != 1) begin
         errors++;
         $display("FAIL cnt_wrap: STEP_CNT=%h pulses=%0d, want 0000 and 1",
                  bus.STEP_CNT, obs_q.size());
      end
      obs_q.delete();
   endtask

   task automatic test_rst_mid_seq();
      int e, o;
      cyc();
      bus.KEY = 2'b00;
      cyc();
      checks++;
      if (bus.CPU_RST !== 1'b1) begin
         errors++;
         $display("FAIL chord_rstseq: CPU_RST=%b, want 1", bus.CPU_RST);
      end
      repeat (5) cyc();
      RST = 1'b1;
      cyc();
      checks++;
      if ({bus.CPU_EN, bus.CPU_RST, bus.RUNNING} !== 3'b000 || bus.STEP_CNT !== 16'h0000) begin
         errors++;
         $display("FAIL rst_mid_seq: en/rst/run=%b cnt=%h, want 000 cnt=0000",
                  {bus.CPU_EN, bus.CPU_RST, bus.RUNNING}, bus.STEP_CNT);
      end
      RST = 1'b0;
      bus.KEY = 2'b11;
      repeat (RST_CYC + 4) begin
         cyc();
         checks++;
         if (bus.CPU_RST !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_hold: CPU_RST=%b, want 0", bus.CPU_RST);
         end
      end
      bus.KEY = 2'b10;
      exp_q.push_back(cyc_n + 1);
      cyc();
      bus.KEY = 2'b11;
      repeat (2) cyc();
      checks++;
      if (bus.STEP_CNT !== 16'd1) begin
         errors++;
         $display("FAIL rst_mid_step: STEP_CNT=%0d, want 1", bus.STEP_CNT);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rst_mid_pulse: CPU_EN at cycle %0d, want cycle %0d", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL rst_mid_extra: %0d extra CPU_EN cycles, want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_slow_run();
      test_vslow_run();
      test_breakpoint();
      test_rstseq();
      test_cnt_wrap();
      test_rst_mid_seq();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
